// File: rtl/game_menu_pkg.sv
// game_menu_pkg: shared types, colour table and geometry helper for the game menu
package game_menu_pkg;
  typedef enum logic [1:0] {BROWSE, CONFIRM, LOCKED} state_t;
  localparam logic [11:0] HIGHLIGHT = 12'hFFF;
  localparam logic [11:0] COLORS [8] = '{12'h4DE, 12'h0F0, 12'h009, 12'hFF0,
                                         12'hF00, 12'hFA0, 12'h80F, 12'h0FF};
  function automatic int panel_w(input int hs_min, input int hs_max, input int n, input int pillar);
    return (hs_max - hs_min + 1 - (n + 1) * pillar) / n;
  endfunction
endpackage

// File: rtl/game_menu_btn_edge.sv
// game_menu_btn_edge: registers 4 button levels once and flags their rising edges
//   clk, rst (async, active-high), btn[3:0] levels in, rise[3:0] one-cycle edge pulses out
module game_menu_btn_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [3:0] rise
);
  logic [3:0] q, d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= '0;
      d <= '0;
    end else begin
      q <= btn;
      d <= q;
    end
  assign rise = q & ~d;
endmodule

// File: rtl/game_menu_selector.sv
// game_menu_selector: N-panel VGA game menu with blinking cursor and confirm/lock FSM
//   in : clk, rst (async, active-high), btn_left/right/select/back, Coloana, Linie, InDisplay, VS (active-low)
//   out: red/green/blue (2-cycle latency), cursor, sel_game, game_start (pulse), game_active
//   GAME_MENU_WRAP_EN defined: cursor wraps at the ends; undefined: cursor saturates
module game_menu_selector
  import game_menu_pkg::*;
#(
  parameter int N_GAMES        = 4,
  parameter int PILLAR_W       = 24,
  parameter int BORDER_W       = 4,
  parameter int HS_MIN         = 144,
  parameter int HS_MAX         = 783,
  parameter int VS_MIN         = 32,
  parameter int VS_MAX         = 511,
  parameter int BLINK_FRAMES   = 30,
  parameter int CONFIRM_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_select,
  input  logic       btn_back,
  input  logic [9:0] Coloana,
  input  logic [9:0] Linie,
  input  logic       InDisplay,
  input  logic       VS,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic [2:0] cursor,
  output logic [2:0] sel_game,
  output logic       game_start,
  output logic       game_active
);
  localparam int PW = panel_w(HS_MIN, HS_MAX, N_GAMES, PILLAR_W);
  localparam logic [2:0] LAST = 3'(N_GAMES - 1);
  localparam logic [15:0] BK_LAST = 16'(BLINK_FRAMES - 1);
  localparam logic [15:0] CF_LAST = 16'(CONFIRM_FRAMES - 1);
  logic [3:0] rise;
  logic l, r, s, b, up, dn, tick, vs_q, vs_d;
  logic [2:0] cur_q, cur_n, inc, dec, sel_q, pan_n, pan_q;
  logic [15:0] cf_q, cf_n, bk_q, bk_n;
  logic blink_q, blink_n, start_q, pil_n, pil_q, brd_n, brd_q, disp_q, hl;
  logic [11:0] base, rgb_n, rgb_q;
  state_t state_q, state_n;
  int col, lin, off;
  game_menu_btn_edge u_edge (
    .clk (clk),
    .rst (rst),
    .btn ({btn_back, btn_select, btn_right, btn_left}),
    .rise(rise)
  );
  assign {b, s, r, l} = rise;
  assign tick = vs_d & ~vs_q;
  assign inc = cur_q == LAST ? '0 : cur_q + 3'd1;
  assign dec = cur_q == '0 ? LAST : cur_q - 3'd1;
`ifdef GAME_MENU_WRAP_EN
  assign up = r & ~l;
  assign dn = l & ~r;
`else
  // at a limit the edge is not a move, so blink timing is left alone
  assign up = r & ~l & (cur_q != LAST);
  assign dn = l & ~r & (cur_q != '0);
`endif
  always_comb begin
    state_n = state_q;
    cur_n   = cur_q;
    cf_n    = cf_q;
    bk_n    = tick ? (bk_q == BK_LAST ? '0 : bk_q + 16'd1) : bk_q;
    blink_n = tick && bk_q == BK_LAST ? ~blink_q : blink_q;
    case (state_q)
      BROWSE:
        if (s) state_n = CONFIRM;
        else if (up || dn) begin
          cur_n   = up ? inc : dec;
          bk_n    = '0;
          blink_n = 1'b1;
        end
      CONFIRM:
        if (b) begin
          state_n = BROWSE;
          cf_n    = '0;
        end else if (tick) begin
          state_n = cf_q == CF_LAST ? LOCKED : CONFIRM;
          cf_n    = cf_q == CF_LAST ? '0 : cf_q + 16'd1;
        end
      LOCKED:
        if (b) state_n = BROWSE;
      default: state_n = BROWSE;
    endcase
  end
  // parallel per-panel range compare; the last match wins, panels never overlap
  always_comb begin
    col   = int'(Coloana);
    lin   = int'(Linie);
    off   = 0;
    pan_n = '0;
    pil_n = 1'b1;
    brd_n = 1'b0;
    for (int i = 0; i < N_GAMES; i++) begin
      off = col - (HS_MIN + PILLAR_W + i * (PW + PILLAR_W));
      if (off >= 0 && off < PW) begin
        pan_n = 3'(i);
        pil_n = 1'b0;
        brd_n = off < BORDER_W || off >= PW - BORDER_W || lin < VS_MIN + BORDER_W || lin > VS_MAX - BORDER_W;
      end
    end
  end
  assign hl   = pan_q == cur_q;
  assign base = COLORS[pan_q];
  assign rgb_n = !disp_q || pil_q                                     ? 12'h000 :
                 hl && brd_q && (blink_q || state_q != BROWSE)         ? HIGHLIGHT :
                 hl && state_q == CONFIRM && cf_q[2]                   ? HIGHLIGHT :
                 state_q == LOCKED && pan_q != sel_q                   ? {1'b0, base[11:9], 1'b0, base[7:5], 1'b0, base[3:1]} :
                 base;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vs_q    <= 1'b0;
      vs_d    <= 1'b0;
      state_q <= BROWSE;
      cur_q   <= '0;
      cf_q    <= '0;
      bk_q    <= '0;
      blink_q <= 1'b1;
      sel_q   <= '0;
      start_q <= 1'b0;
      pan_q   <= '0;
      pil_q   <= 1'b0;
      brd_q   <= 1'b0;
      disp_q  <= 1'b0;
      rgb_q   <= '0;
    end else begin
      vs_q    <= VS;
      vs_d    <= vs_q;
      state_q <= state_n;
      cur_q   <= cur_n;
      cf_q    <= cf_n;
      bk_q    <= bk_n;
      blink_q <= blink_n;
      start_q <= state_q == CONFIRM && state_n == LOCKED;
      if (state_q == CONFIRM && state_n == LOCKED) sel_q <= cur_q;
      pan_q   <= pan_n;
      pil_q   <= pil_n;
      brd_q   <= brd_n;
      disp_q  <= InDisplay;
      rgb_q   <= rgb_n;
    end
  assign {red, green, blue} = rgb_q;
  assign cursor      = cur_q;
  assign sel_game    = sel_q;
  assign game_start  = start_q;
  assign game_active = state_q == LOCKED;
endmodule

// File: tb/tb_game_menu_selector.sv
// tb_game_menu_selector: scoreboard bench for game_menu_selector at default parameters
module tb_game_menu_selector;
  logic clk = 0, rst = 1;
  logic btn_left = 0, btn_right = 0, btn_select = 0, btn_back = 0;
  logic [9:0] Coloana = 0, Linie = 0;
  logic InDisplay = 0, VS = 1;
  logic [3:0] red, green, blue;
  logic [2:0] cursor, sel_game;
  logic game_start, game_active;
  int n_cmp = 0, n_err = 0, start_cycles = 0;
  int px_col[$], px_lin[$];
  logic px_dis[$];
  logic [11:0] exp_q[$], got_q[$];
  string tag_q[$];

  always #5 clk = ~clk;
  always @(negedge clk) if (game_start) start_cycles++;

  game_menu_selector dut (
    .clk(clk), .rst(rst),
    .btn_left(btn_left), .btn_right(btn_right), .btn_select(btn_select), .btn_back(btn_back),
    .Coloana(Coloana), .Linie(Linie), .InDisplay(InDisplay), .VS(VS),
    .red(red), .green(green), .blue(blue),
    .cursor(cursor), .sel_game(sel_game), .game_start(game_start), .game_active(game_active)
  );

  task automatic px(input int c, input int l, input logic d, input logic [11:0] e, input string t);
    px_col.push_back(c); px_lin.push_back(l); px_dis.push_back(d);
    exp_q.push_back(e); tag_q.push_back(t);
  endtask

  // drive one coordinate per cycle and collect the colour two cycles later
  task automatic run_pixels();
    int n = px_col.size();
    for (int k = 0; k < n + 2; k++) begin
      @(posedge clk); #1;
      if (k < n) begin
        Coloana = 10'(px_col[k]); Linie = 10'(px_lin[k]); InDisplay = px_dis[k];
      end else InDisplay = 0;
      @(negedge clk);
      if (k >= 2) got_q.push_back({red, green, blue});
    end
    px_col.delete(); px_lin.delete(); px_dis.delete();
  endtask

  task automatic press(input logic [3:0] m);
    @(posedge clk); #1;
    {btn_back, btn_select, btn_right, btn_left} = m;
    @(posedge clk); #1;
    {btn_back, btn_select, btn_right, btn_left} = 4'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(posedge clk); #1 VS = 0;
      repeat (2) @(posedge clk);
      #1 VS = 1;
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({red, green, blue} !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h want 000", {red, green, blue}); end
    n_cmp++; if (cursor !== 3'd0) begin n_err++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
    n_cmp++; if (sel_game !== 3'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", sel_game); end
    n_cmp++; if (game_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", game_start); end
    n_cmp++; if (game_active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", game_active); end
    @(posedge clk); #1 rst = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_scan();
    logic [11:0] e, g;
    string t;
    px(144, 200, 1, 12'h000, "pillar_144"); px(167, 200, 1, 12'h000, "pillar_167");
    px(298, 200, 1, 12'h000, "pillar_298"); px(321, 200, 1, 12'h000, "pillar_321");
    px(760, 200, 1, 12'h000, "pillar_760"); px(783, 200, 1, 12'h000, "pillar_783");
    px(200, 200, 1, 12'h4DE, "panel0_fill"); px(500, 200, 1, 12'h009, "panel2_fill");
    px(400, 200, 1, 12'h0F0, "panel1_fill"); px(700, 200, 1, 12'hFF0, "panel3_fill");
    px(168, 200, 1, 12'hFFF, "panel0_border"); px(200, 33, 1, 12'hFFF, "panel0_top_border");
    px(200, 200, 0, 12'h000, "blanking");
    run_pixels();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL %s: got %h want %h", t, g, e); end
    end
  endtask

  task automatic test_cursor();
    @(posedge clk); #1 btn_right = 1;
    @(posedge clk); #1 btn_right = 0;
    @(negedge clk);
    n_cmp++; if (cursor !== 3'd0) begin n_err++; $display("FAIL cursor_latency1: got %0d want 0", cursor); end
    @(negedge clk);
    n_cmp++; if (cursor !== 3'd1) begin n_err++; $display("FAIL cursor_latency2: got %0d want 1", cursor); end
    repeat (3) @(posedge clk);
    press(4'b0010); press(4'b0010);
    n_cmp++; if (cursor !== 3'd3) begin n_err++; $display("FAIL cursor_right3: got %0d want 3", cursor); end
    press(4'b0010);
`ifdef GAME_MENU_WRAP_EN
    n_cmp++; if (cursor !== 3'd0) begin n_err++; $display("FAIL cursor_end: got %0d want 0", cursor); end
    press(4'b0001);
`else
    n_cmp++; if (cursor !== 3'd3) begin n_err++; $display("FAIL cursor_end: got %0d want 3", cursor); end
`endif
    n_cmp++; if (cursor !== 3'd3) begin n_err++; $display("FAIL cursor_back3: got %0d want 3", cursor); end
  endtask

  task automatic blink_probe(input int c, input logic [11:0] e0, input string t);
    logic [11:0] e, g;
    string tt;
    px(c, 200, 1, e0, t);
    run_pixels();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); tt = tag_q.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL %s: got %h want %h", tt, g, e); end
    end
  endtask

  task automatic test_blink();
    blink_probe(630, 12'hFFF, "blink_start");
    frames(29); blink_probe(630, 12'hFFF, "blink_f29");
    frames(1);  blink_probe(630, 12'hFF0, "blink_f30");
    frames(29); blink_probe(630, 12'hFF0, "blink_f59");
    frames(1);  blink_probe(630, 12'hFFF, "blink_f60");
    frames(35); blink_probe(630, 12'hFF0, "blink_f95");
    press(4'b0001);
    n_cmp++; if (cursor !== 3'd2) begin n_err++; $display("FAIL blink_move: got %0d want 2", cursor); end
    blink_probe(476, 12'hFFF, "blink_restart");
    blink_probe(630, 12'hFF0, "blink_old_panel");
  endtask

  task automatic test_confirm_abort();
    int s0 = start_cycles;
    press(4'b0100);
    n_cmp++; if (cursor !== 3'd2) begin n_err++; $display("FAIL select_cursor: got %0d want 2", cursor); end
    press(4'b0010);
    n_cmp++; if (cursor !== 3'd2) begin n_err++; $display("FAIL confirm_ignore_right: got %0d want 2", cursor); end
    frames(4);
    blink_probe(500, 12'hFFF, "confirm_fill_flash");
    blink_probe(476, 12'hFFF, "confirm_border");
    frames(6);
    blink_probe(500, 12'h009, "confirm_fill_plain");
    press(4'b1000);
    frames(55);
    n_cmp++; if (game_active !== 1'b0) begin n_err++; $display("FAIL abort_active: got %b want 0", game_active); end
    n_cmp++; if (start_cycles !== s0) begin n_err++; $display("FAIL abort_start: got %0d want %0d", start_cycles, s0); end
    press(4'b0010);
    n_cmp++; if (cursor !== 3'd3) begin n_err++; $display("FAIL abort_browse: got %0d want 3", cursor); end
    press(4'b0011);
    n_cmp++; if (cursor !== 3'd3) begin n_err++; $display("FAIL left_right_same: got %0d want 3", cursor); end
    press(4'b0001); press(4'b0001);
    n_cmp++; if (cursor !== 3'd1) begin n_err++; $display("FAIL left_twice: got %0d want 1", cursor); end
  endtask

  task automatic test_lock();
    int s0 = start_cycles;
    press(4'b0100);
    frames(59);
    n_cmp++; if (game_active !== 1'b0) begin n_err++; $display("FAIL lock_early: got %b want 0", game_active); end
    n_cmp++; if (start_cycles !== s0) begin n_err++; $display("FAIL start_early: got %0d want %0d", start_cycles, s0); end
    frames(1);
    n_cmp++; if (start_cycles !== s0 + 1) begin n_err++; $display("FAIL start_pulse_width: got %0d want %0d", start_cycles - s0, 1); end
    n_cmp++; if (sel_game !== 3'd1) begin n_err++; $display("FAIL lock_sel: got %0d want 1", sel_game); end
    n_cmp++; if (game_active !== 1'b1) begin n_err++; $display("FAIL lock_active: got %b want 1", game_active); end
    blink_probe(200, 12'h267, "locked_dim0");
    blink_probe(500, 12'h004, "locked_dim2");
    blink_probe(400, 12'h0F0, "locked_sel_fill");
    blink_probe(322, 12'hFFF, "locked_border");
    press(4'b0010);
    n_cmp++; if (cursor !== 3'd1) begin n_err++; $display("FAIL lock_ignore_right: got %0d want 1", cursor); end
    press(4'b1000);
    n_cmp++; if (game_active !== 1'b0) begin n_err++; $display("FAIL back_active: got %b want 0", game_active); end
    n_cmp++; if (sel_game !== 3'd1) begin n_err++; $display("FAIL back_sel_hold: got %0d want 1", sel_game); end
    press(4'b0110);
    n_cmp++; if (cursor !== 3'd1) begin n_err++; $display("FAIL select_wins: got %0d want 1", cursor); end
    frames(60);
    n_cmp++; if (game_active !== 1'b1) begin n_err++; $display("FAIL relock_active: got %b want 1", game_active); end
    n_cmp++; if (start_cycles !== s0 + 2) begin n_err++; $display("FAIL relock_start: got %0d want %0d", start_cycles - s0, 2); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    Coloana = 10'd400; Linie = 10'd200; InDisplay = 1;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if ({red, green, blue} !== 12'h0F0) begin n_err++; $display("FAIL pre_reset_rgb: got %h want 0f0", {red, green, blue}); end
    rst = 1;
    #1;
    n_cmp++; if ({red, green, blue} !== 12'h000) begin n_err++; $display("FAIL async_rgb: got %h want 000", {red, green, blue}); end
    n_cmp++; if (cursor !== 3'd0) begin n_err++; $display("FAIL async_cursor: got %0d want 0", cursor); end
    n_cmp++; if (sel_game !== 3'd0) begin n_err++; $display("FAIL async_sel: got %0d want 0", sel_game); end
    n_cmp++; if (game_active !== 1'b0) begin n_err++; $display("FAIL async_active: got %b want 0", game_active); end
    @(posedge clk); #1 rst = 0; InDisplay = 0;
    repeat (3) @(posedge clk);
    blink_probe(200, 12'h4DE, "after_reset_fill");
    blink_probe(168, 12'hFFF, "after_reset_border");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_cursor();
    test_blink();
    test_confirm_abort();
    test_lock();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/game_menu_selector.md
# game_menu_selector

Parametrised game-selection menu renderer with interactive cursor. It splits the visible VGA area into `N_GAMES` coloured panels separated by black pillars and moves a blinking highlight border across the panels from button input. A confirm/lock state machine reports the chosen game to the console top level. It sits between the VGA timing generator (`Coloana`, `Linie`, `InDisplay`, `VS`) and the RGB output mux.

## Interface
- `N_GAMES`, 4: number of panels, 2..8.
- `PILLAR_W`, 24: pillar width in pixels.
- `BORDER_W`, 4: highlight border thickness in pixels.
- `HS_MIN` / `HS_MAX`, 144 / 783: first and last visible column.
- `VS_MIN` / `VS_MAX`, 32 / 511: first and last visible line.
- `BLINK_FRAMES`, 30: frames per blink half-period.
- `CONFIRM_FRAMES`, 60: frames spent in CONFIRM.

Ports:
- `clk`  in  1: pixel clock.
- `rst`  in  1: asynchronous, active-high reset.
- `btn_left`, `btn_right`, `btn_select`, `btn_back`  in  1 each: debounced levels, synchronous to `clk`.
- `Coloana`  in  10: current column.
- `Linie`  in  10: current line.
- `InDisplay`  in  1: visible-area flag.
- `VS`  in  1: vertical sync, active-low.
- `red`, `green`, `blue`  out  4 each: pixel colour.
- `cursor`  out  3: highlighted panel index.
- `sel_game`  out  3: locked game index.
- `game_start`  out  1: one-cycle pulse on entering LOCKED.
- `game_active`  out  1: high while in LOCKED.

## Operation
- Panel geometry:
  - `PANEL_W = (HS_MAX-HS_MIN+1-(N_GAMES+1)*PILLAR_W)/N_GAMES`, computed at elaboration.
  - Panel i spans `HS_MIN+PILLAR_W+i*(PANEL_W+PILLAR_W)` for `PANEL_W` columns.
  - All other visible columns, including the remainder at the right edge, are pillar (black).
- Panel index is decoded with parallel comparators. No divider is used.
- Frame tick: one-cycle pulse on a registered `VS` 1→0 edge.
- Buttons: each input is registered once, then rising-edge detected. Levels are ignored; only edges act.
- FSM states:
  - BROWSE:
    - left/right edge moves `cursor` by -1/+1 (end behaviour per Configuration).
    - left and right in the same cycle: no move.
    - select edge: go to CONFIRM. Select wins over a same-cycle left/right, and the cursor is unchanged.
    - back: ignored.
  - CONFIRM:
    - Counts `CONFIRM_FRAMES` frame ticks, then goes to LOCKED.
    - back edge: abort to BROWSE with the frame counter cleared.
    - left/right/select: ignored.
  - LOCKED:
    - On entry: `sel_game <= cursor` and a one-cycle `game_start` pulse. `game_active` is high in this state.
    - back edge: return to BROWSE; `game_active` falls the next cycle. `sel_game` holds its value.
    - All other buttons: ignored.
- Blink: counter of frame ticks, 0..`BLINK_FRAMES`-1. On wrap it toggles `blink_on`. Any cursor move resets the counter to 0 and sets `blink_on=1`.
- Colour priority, highest first:
  1. Not `InDisplay`: black.
  2. Pillar: black.
  3. Highlighted panel border (within `BORDER_W` of the panel's left/right edge, or of `VS_MIN`/`VS_MAX`): white F/F/F. Shown when `blink_on` in BROWSE; always shown in CONFIRM and LOCKED.
  4. Panel fill: base colour from the package table.
     - In CONFIRM, the highlighted panel fill is white while frame counter bit 2 is 1.
     - In LOCKED, non-selected panels have each channel shifted right by 1.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The next frame renders BROWSE with cursor 0.

## Timing
- RGB latency: 2 cycles from `Coloana`/`Linie`/`InDisplay`.
  - Stage 1 registers region decode: panel index, pillar flag, border flag, display flag.
  - Stage 2 registers the colour.
- `cursor` updates 2 cycles after a button rising edge: 1 cycle input register, 1 cycle FSM.
- State changes take effect on pixels one pipeline-flush later. No tearing protection is provided.
- Reset values:
  - `red`/`green`/`blue` = 0, `cursor` = 0, `sel_game` = 0, `game_start` = 0, `game_active` = 0.
  - State = BROWSE, `blink_on` = 1, counters = 0.

## Configuration
- `GAME_MENU_WRAP_EN` defined: cursor wraps around (`N_GAMES`-1 → 0 on right, 0 → `N_GAMES`-1 on left).
- Undefined: cursor saturates at 0 and `N_GAMES`-1. An edge at the limit leaves the blink counter untouched.

## Structure
- `game_menu_pkg` holds:
  - state enum (BROWSE, CONFIRM, LOCKED);
  - 8-entry base colour table: 0: 4/D/E, 1: 0/F/0, 2: 0/0/9, 3: F/F/0, 4: F/0/0, 5: F/A/0, 6: 8/0/F, 7: 0/F/F;
  - highlight colour constant;
  - `PANEL_W` helper function.
- Sub-module `game_menu_btn_edge`: 4-bit input register plus rising-edge detector, reset to 0.

## Test plan
- Reset, then scan line 200 with defaults → black at cols 144–167, 298–321, 760–783; panel 0 at col 200 = 4/D/E; panel 2 at col 500 = 0/0/9. Each pixel appears 2 cycles after its coordinates.
- `btn_right` pulse ×3 → `cursor`=3. One more: `cursor`=0 with `GAME_MENU_WRAP_EN` defined, 3 without.
- Border pixel col 630, line 200 with cursor 3 → white for 30 frames, then panel colour for 30 frames. A cursor move mid-period restarts with border visible.
- `btn_select` at cursor 1, then 60 VS falling edges → `game_start` high exactly 1 cycle, `sel_game`=1, `game_active`=1. Panel 0 at col 200 = 2/6/7.
- `btn_back` after 10 frames in CONFIRM → BROWSE, no `game_start` pulse. `btn_left` and `btn_right` in the same cycle → `cursor` unchanged.
- Assert `rst` while LOCKED → all outputs 0 asynchronously, before the next `clk` edge.
